vga_sync: RTL
=============

Name: vga_sync

Overview:
- Timing generator for 640x480@60 Hz VGA, clocked from the 25 MHz pixel clock.
- Produces the raster coordinates x/y, visible-area flag vga_on, hsync/vsync and per-line/per-frame strobes.
- Sits directly upstream of the ball, paddle and pixel-mux stages, which consume x, y, vga_on and frame_tick.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk25M  input  1  pixel clock, 25 MHz
- reset  input  1  asynchronous, active-high reset
- x  output  10  horizontal counter, 0..H_TOTAL-1
- y  output  10  vertical counter, 0..V_TOTAL-1
- vga_on  output  1  high when x<H_VISIBLE and y<V_VISIBLE
- hsync  output  1  horizontal sync, level per SYNC_POL
- vsync  output  1  vertical sync, level per SYNC_POL
- line_tick  output  1  one-clock pulse on the last clock of each line
- frame_tick  output  1  one-clock pulse at start of vertical blank
- rgb_test  output  3  test-pattern colour (see Optional Feature)

Behaviour:
- Reset: clk25M and reset — reset is asynchronous, active-high; clock is clk25M.
- Derived totals: H_TOTAL = sum of the four H_* parameters (800 by default); V_TOTAL = sum of the four V_* parameters (525 by default).
- Counter x:
  - increments every clock;
  - at x==H_TOTAL-1 it wraps to 0 and y advances.
- Counter y:
  - increments only on the x wrap;
  - at y==V_TOTAL-1 together with the x wrap, y wraps to 0.
- All outputs are registered.
  - hsync, vsync, vga_on, line_tick and frame_tick are decoded from the next-state counter values, so they are cycle-aligned with the x/y they describe: zero relative latency, no combinational decode glitches.
- hsync active when H_VISIBLE+H_FRONT <= x <= H_VISIBLE+H_FRONT+H_SYNC-1, i.e. 656..751.
- vsync active when V_VISIBLE+V_FRONT <= y <= V_VISIBLE+V_FRONT+V_SYNC-1, i.e. 490..491.
- Active level = SYNC_POL; inactive level = ~SYNC_POL.
- line_tick = 1 exactly when x==H_TOTAL-1, for every line including blanking lines.
- frame_tick = 1 exactly when x==0 and y==V_VISIBLE (480): one clock per frame, first clock of vblank.
  - Downstream motion logic updates positions on this strobe.
- Reset values: x=0, y=0, vga_on=1 (consistent with decode of (0,0)), hsync=~SYNC_POL, vsync=~SYNC_POL, line_tick=0, frame_tick=0, rgb_test=0.
- Reset asserted mid-frame: all outputs go to their reset values immediately. Counting restarts from (0,0) on the first clock after deassertion. No partial pulses are held over.
- Widths: counters are 10 bits; H_TOTAL and V_TOTAL must both be <=1024. Compare operations are unsigned.
- Frame period: H_TOTAL*V_TOTAL = 420000 clocks (~59.5 Hz at 25 MHz).

Optional Feature:
- Macro: VGA_TESTPAT_EN.
- Defined: rgb_test shows 8 vertical colour bars while vga_on=1.
  - Bar index = x[9:4] / 5, i.e. 80-pixel bars; bar i drives colour i, 3'b000..3'b111.
  - rgb_test=0 whenever vga_on=0.
  - Registered and aligned with x/y.
- Undefined: rgb_test is tied to 3'b000; no extra logic.

Test Plan:
- Reset release, 801 clocks -> x counts 0..799, returns to 0 at clock 800; y becomes 1 at the same edge; line_tick high only while x==799.
- Run one line -> hsync low exactly for x=656..751 (96 clocks), high elsewhere; vga_on low for x>=640.
- Run full frame (420000 clocks) -> vsync low for y=490..491 only (1600 clocks); frame_tick high exactly once, at (0,480); y wraps 524->0 together with x 799->0.
- Assert reset at x=300, y=200 for 3 clocks -> outputs take reset values asynchronously; after release, x=1, y=0 on the first edge; the next frame_tick appears after exactly 480*800 clocks.
- SYNC_POL=1 build -> hsync/vsync idle 0 and pulse high over the same windows.
- With VGA_TESTPAT_EN: x=0 -> rgb_test=000; x=80 -> 001; x=639 -> 111; x=640 -> 000. Without the macro, rgb_test is always 000.

Source files
------------

// File: rtl/vga_sync.sv
// vga_sync: 640x480@60 Hz VGA raster timing generator on the 25 MHz pixel clock.
//
// x/y raster counters with registered sync, visible-area and strobe outputs.
// Every output is decoded from the next-state counter values and then
// registered. This keeps each flag aligned with the x/y value it describes,
// and the outputs cannot glitch.
//
// Build option: define VGA_TESTPAT_EN to drive rgb_test with eight 80-pixel
// vertical colour bars. Without it, rgb_test is a constant 3'b000.

module vga_sync #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk25M,
  input  logic       reset,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       vga_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_tick,
  output logic       frame_tick,
  output logic [2:0] rgb_test
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // All compares are on 10-bit unsigned counter values.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  localparam logic SYNC_ACT  = SYNC_POL;
  localparam logic SYNC_IDLE = ~SYNC_POL;

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       vga_on_q, vga_on_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_tick_q, line_tick_d;
  logic       frame_tick_q, frame_tick_d;
  logic       x_wrap;

  // Next raster position, and the output decode of that next position.
  always_comb begin
    x_wrap = (x_q == H_LAST);
    x_d    = x_wrap ? 10'd0 : x_q + 10'd1;
    y_d    = y_q;
    if (x_wrap) begin
      y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
    end

    vga_on_d     = (x_d < H_VIS) && (y_d < V_VIS);
    hsync_d      = ((x_d >= HS_START) && (x_d <= HS_END)) ? SYNC_ACT : SYNC_IDLE;
    vsync_d      = ((y_d >= VS_START) && (y_d <= VS_END)) ? SYNC_ACT : SYNC_IDLE;
    line_tick_d  = (x_d == H_LAST);
    frame_tick_d = (x_d == 10'd0) && (y_d == V_VIS);
  end

  // Counter and timing-output registers. Reset values match the decode of (0,0).
  always_ff @(posedge clk25M or posedge reset) begin
    if (reset) begin
      x_q          <= 10'd0;
      y_q          <= 10'd0;
      vga_on_q     <= 1'b1;
      hsync_q      <= SYNC_IDLE;
      vsync_q      <= SYNC_IDLE;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      vga_on_q     <= vga_on_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign vga_on     = vga_on_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;

`ifdef VGA_TESTPAT_EN
  logic [5:0] col_blk;
  logic [2:0] rgb_q, rgb_d;

  // Bar colour for the next pixel: 16-pixel column blocks, five blocks per bar.
  always_comb begin
    col_blk = x_d[9:4];
    rgb_d   = vga_on_d ? 3'(col_blk / 6'd5) : 3'b000;
  end

  // Test-pattern register, aligned with x/y like the other outputs.
  always_ff @(posedge clk25M or posedge reset) begin
    if (reset) begin
      rgb_q <= 3'b000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb_test = rgb_q;
`else
  assign rgb_test = 3'b000;
`endif

endmodule
